country_sensor_filter: RTL and testbench

Upstream conditioning stage for the highway/country signal controller. It takes the raw, asynchronous country-road vehicle detector and produces that controller's X request input. It synchronizes and debounces the detector, then holds a clean request. It uses the controller's country-road signal as feedback, so it can cap how long the country road holds green and prevent highway starvation.

---
 rtl/country_sensor_filter.sv | 74 +++++++
 tb/tb_country_sensor_filter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/country_sensor_filter.sv
// country_sensor_filter: synchronizes and debounces the country-road detector, then issues
// a request to the signal controller that is capped while the country road is green.
module country_sensor_filter #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_SERVE  = 16,
  parameter int LOCKOUT    = 8,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       car_raw,
  input  logic [1:0] contry,
  output logic       X,
  output logic       car_present,
  output logic       lockout
);
  typedef enum logic [1:0] {IDLE, REQ, SERVE, LOCK} state_t;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] SRV_LAST = CW'(MAX_SERVE - 1);
  localparam logic [CW-1:0] LCK_LAST = CW'(LOCKOUT - 1);
  state_t state;
  logic s1, car_s, green;
  logic [CW-1:0] deb_cnt, srv_cnt, lck_cnt;
  assign green = contry == 2'b10;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      car_s <= 1'b0;
      deb_cnt <= '0;
      car_present <= 1'b0;
    end else begin
      s1 <= car_raw;
      car_s <= s1;
      if (car_s == car_present) deb_cnt <= '0;
      else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        car_present <= ~car_present;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end
  // serve and lockout counters saturate rather than wrap
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      srv_cnt <= '0;
      lck_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (car_present) state <= REQ;
        REQ: begin
          if (green) begin
            state <= SERVE;
            srv_cnt <= '0;
          end else if (!car_present) state <= IDLE;
        end
        SERVE: begin
          srv_cnt <= srv_cnt + CW'(~&srv_cnt);
          if (!car_present || !green) state <= IDLE;
          else if (srv_cnt == SRV_LAST) begin
            state <= LOCK;
            lck_cnt <= '0;
          end
        end
        LOCK: begin
          lck_cnt <= lck_cnt + CW'(~&lck_cnt);
          if (lck_cnt == LCK_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign X = (state == REQ) || (state == SERVE);
  assign lockout = state == LOCK;
endmodule

// File: tb/tb_country_sensor_filter.sv
// tb_country_sensor_filter: directed + random stimulus; a cycle model pushes expected outputs
// into a queue and an independent monitor compares them against the DUT.
module tb_country_sensor_filter;
  localparam int DEB = 4, MS = 16, LO = 8;
  logic clk = 1'b0, clr_n = 1'b0, car_raw = 1'b0;
  logic [1:0] contry = 2'b00;
  logic X, car_present, lockout;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  country_sensor_filter #(.DEB_CYCLES(DEB), .MAX_SERVE(MS), .LOCKOUT(LO), .CW(8)) dut (
    .clk(clk), .clr_n(clr_n), .car_raw(car_raw), .contry(contry),
    .X(X), .car_present(car_present), .lockout(lockout)
  );

  typedef enum {M_IDLE, M_REQ, M_SERVE, M_LOCK} mode_t;
  mode_t mode = M_IDLE;
  bit hist[$] = '{1'b0, 1'b0};
  bit pres = 1'b0;
  int run = 0, served = 0, lock_left = 0;
  logic [2:0] expq[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: sync is a two-deep history, debounce a mismatch run length,
  // the serve cap an edge count since green began, the lockout a countdown
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist = '{1'b0, 1'b0};
      pres = 1'b0;
      run = 0;
      mode = M_IDLE;
      served = 0;
      lock_left = 0;
      if (clk) expq.push_back(3'b000);
    end else begin
      bit cs, op, g;
      cs = hist[1];
      op = pres;
      g = contry == 2'b10;
      if (cs != pres) begin
        run++;
        if (run == DEB) begin
          pres = !pres;
          run = 0;
        end
      end else run = 0;
      case (mode)
        M_IDLE: if (op) mode = M_REQ;
        M_REQ: begin
          if (g) begin
            mode = M_SERVE;
            served = 0;
          end else if (!op) mode = M_IDLE;
        end
        M_SERVE: begin
          served++;
          if (!op || !g) mode = M_IDLE;
          else if (served == MS) begin
            mode = M_LOCK;
            lock_left = LO;
          end
        end
        M_LOCK: begin
          lock_left--;
          if (lock_left == 0) mode = M_IDLE;
        end
      endcase
      hist.push_front(car_raw);
      void'(hist.pop_back());
      expq.push_back({mode == M_REQ || mode == M_SERVE, pres, mode == M_LOCK});
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (expq.size() == 0) check("queue_empty", 8'd0, 8'd1);
    else check("outputs{X,pres,lock}", {5'd0, X, car_present, lockout}, {5'd0, expq.pop_front()});
  end

  task automatic wait_for(input mode_t m, input int srv, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mode == m && (srv < 0 || served == srv)) && n < 100);
    if (n >= 100) check({"timeout_", name}, 8'd0, 8'd1);
  endtask

  task automatic async_pulse(input string name);
    #2 clr_n = 1'b0;
    #1 check(name, {6'd0, X, lockout}, 8'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic restart_latency(input string name);
    int n = 0;
    @(negedge clk);
    clr_n = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!X && n < 20);
    check(name, 8'(n), 8'd7);
  endtask

  initial begin
    int n, rh, ch;
    car_raw = 1'b1;
    contry = 2'b10;
    repeat (10) @(negedge clk);
    restart_latency("latency_after_reset");
    wait_for(M_SERVE, -1, "serve1");
    async_pulse("async_in_serve");
    restart_latency("latency_after_serve_reset");
    wait_for(M_LOCK, -1, "lock1");
    async_pulse("async_in_lock");
    restart_latency("latency_after_lock_reset");
    wait_for(M_LOCK, -1, "lock2");
    n = 0;
    while (lockout && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lockout_length", 8'(n), 8'(LO));
    @(negedge clk);
    check("req_after_lockout", {7'd0, X}, 8'd1);
    car_raw = 1'b0;
    contry = 2'b00;
    repeat (12) @(negedge clk);
    car_raw = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    car_raw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("glitch_rejected", {6'd0, car_present, X}, 8'd0);
    end
    car_raw = 1'b1;
    wait_for(M_REQ, -1, "req_prio");
    repeat (3) @(negedge clk);
    contry = 2'b10;
    wait_for(M_SERVE, MS - 1, "serve_cap_edge");
    contry = 2'b00;
    @(negedge clk);
    check("green_loss_beats_cap", {6'd0, X, lockout}, 8'd0);
    wait_for(M_REQ, -1, "req_withdraw");
    car_raw = 1'b0;
    repeat (12) @(negedge clk);
    rh = 0;
    ch = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rh == 0) begin
        car_raw = 1'($urandom_range(0, 1));
        rh = int'($urandom_range(1, 10));
      end
      rh--;
      if (ch == 0) begin
        contry = 2'($urandom_range(0, 3));
        ch = int'($urandom_range(1, 25));
      end
      ch--;
      if ($urandom_range(0, 499) == 0) begin
        #2 clr_n = 1'b0;
        #1 check("async_random", {6'd0, X, lockout}, 8'd0);
        @(negedge clk);
        clr_n = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
